// File: rtl/sram_dual_responder_if.sv
// sram_dual_responder_if: the two SRAM-like request ports (fetch and data)
// plus the stall request back to pipeline control.
interface sram_dual_responder_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq;

  // Core side: issues requests, consumes read data and the stall request.
  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  inst_sram_rdata, data_sram_rdata, stallreq
  );

  // Memory side: serves requests and drives read data and the stall request.
  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output inst_sram_rdata, data_sram_rdata, stallreq
  );
endinterface

// File: rtl/sram_dual_responder.sv
// sram_dual_responder: one single-port word RAM shared by a read-only fetch
// port and a load/store data port, with 1-cycle read latency. On a same-cycle
// conflict the data access goes first and the fetch is replayed the next cycle
// while stallreq is high.
// Optional macro SRAM_RESP_ADDR_CHK_EN: out-of-window requests read
// 32'hDEAD_BEEF, never write, and set the sticky addr_err output.
module sram_dual_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE       = 32'h1FC0_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_dual_responder_if.slave  bus
`ifdef SRAM_RESP_ADDR_CHK_EN
  ,
  output logic                  addr_err
`endif
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;
  localparam logic [31:0] BAD_WORD  = 32'hDEAD_BEEF;

  typedef enum logic {IDLE, INST_PEND} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             inst_rdata_q, inst_rdata_d;
  logic [31:0]             data_rdata_q, data_rdata_d;
  logic [31:0]             inst_addr_q, inst_addr_d;
  logic                    stall_q, stall_d;
  logic                    err_q, err_d;

  logic [31:0]             inst_phys, data_phys;
  logic [DEPTH_LOG2-1:0]   inst_idx, data_idx, pend_idx;
  logic                    inst_ok, data_ok, pend_ok;

  logic [31:0]             mem [DEPTH];
  logic                    mem_we;
  logic [3:0]              mem_wbe;
  logic [DEPTH_LOG2-1:0]   mem_widx;
  logic [31:0]             mem_wdata;

  assign inst_phys = bus.inst_sram_addr & PHYS_MASK;
  assign data_phys = bus.data_sram_addr & PHYS_MASK;
  assign inst_idx  = inst_phys[DEPTH_LOG2+1:2];
  assign data_idx  = data_phys[DEPTH_LOG2+1:2];
  assign pend_idx  = inst_addr_q[DEPTH_LOG2+1:2];

`ifdef SRAM_RESP_ADDR_CHK_EN
  localparam logic [32:0] WIN_END = {1'b0, BASE} + (33'd4 << DEPTH_LOG2);

  function automatic logic in_window(input logic [31:0] phys);
    return (phys >= BASE) && ({1'b0, phys} < WIN_END);
  endfunction

  assign inst_ok  = in_window(inst_phys);
  assign data_ok  = in_window(data_phys);
  assign pend_ok  = in_window(inst_addr_q);
  assign addr_err = err_q;
`else
  // Without the range check every address aliases into the RAM.
  assign inst_ok = 1'b1;
  assign data_ok = 1'b1;
  assign pend_ok = 1'b1;
`endif

  // Fetch write data/enables are ignored, and upper/lower address bits are
  // dropped by the word indexing; fold them here so they are not dangling.
  logic unused_ok;
`ifdef SRAM_RESP_ADDR_CHK_EN
  assign unused_ok = ^{bus.inst_sram_wen, bus.inst_sram_wdata};
`else
  assign unused_ok = ^{bus.inst_sram_wen, bus.inst_sram_wdata, inst_phys,
                       data_phys, inst_addr_q, BASE, err_q};
`endif

  // Arbitration, next-state and read-data selection for both ports.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_addr_d  = inst_addr_q;
    stall_d      = 1'b0;
    err_d        = err_q;
    mem_we       = 1'b0;
    mem_wbe      = bus.data_sram_wen;
    mem_widx     = data_idx;
    mem_wdata    = bus.data_sram_wdata;

    unique case (state_q)
      IDLE: begin
        if (bus.data_sram_en) begin
          if (!data_ok) err_d = 1'b1;
          if (bus.data_sram_wen != 4'h0) begin
            mem_we = data_ok;
          end else begin
            data_rdata_d = data_ok ? mem[data_idx] : BAD_WORD;
          end
          // Conflict: park the fetch address and replay it next cycle.
          if (bus.inst_sram_en) begin
            inst_addr_d = inst_phys;
            state_d     = INST_PEND;
            stall_d     = 1'b1;
          end
        end else if (bus.inst_sram_en) begin
          if (!inst_ok) err_d = 1'b1;
          inst_rdata_d = inst_ok ? mem[inst_idx] : BAD_WORD;
        end
      end
      INST_PEND: begin
        // Both ports' live requests are ignored; the core holds them.
        if (!pend_ok) err_d = 1'b1;
        inst_rdata_d = pend_ok ? mem[pend_idx] : BAD_WORD;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte-masked RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM array has no reset; clearing it would turn a RAM macro
    // into thousands of flops, and software never relies on its contents.
    for (int i = 0; i < 4; i++) begin
      if (mem_we && mem_wbe[i]) mem[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // Control and output registers; reset discards any pending fetch.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state_q      <= IDLE;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_addr_q  <= '0;
      stall_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_addr_q  <= inst_addr_d;
      stall_q      <= stall_d;
      err_q        <= err_d;
    end
  end

  assign bus.inst_sram_rdata = inst_rdata_q;
  assign bus.data_sram_rdata = data_rdata_q;
  assign bus.stallreq        = stall_q;

endmodule

// File: doc/sram_dual_responder.md
Name: sram_dual_responder

Overview:
- Memory-side responder for the core's two SRAM-like request ports: inst_sram_* (fetch) and data_sram_* (load/store).
- Backed by one internal single-port word RAM, shared by both ports.
- Returns read data with a fixed one-cycle latency.
- When both ports request in the same cycle, the data request is served first, the fetch is deferred one cycle, and a stall request is raised to the pipeline control.

Parameters:
- DEPTH_LOG2, 12, log2 of RAM depth in 32-bit words. Word index = addr[DEPTH_LOG2+1:2].
- BASE, 32'h1FC0_0000, physical base of the RAM window. Used only by the optional error check.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- inst_sram_en  input  1  fetch request valid.
- inst_sram_wen  input  4  byte write enables. Ignored: the fetch port is read-only.
- inst_sram_addr  input  32  fetch byte address.
- inst_sram_wdata  input  32  ignored.
- inst_sram_rdata  output  32  fetch data, valid the cycle after service.
- data_sram_en  input  1  data request valid.
- data_sram_wen  input  4  byte enables; 0 = read, nonzero = write.
- data_sram_addr  input  32  data byte address.
- data_sram_wdata  input  32  store data; byte i = bits 8i+7:8i.
- data_sram_rdata  output  32  load data, valid the cycle after service.
- stallreq  output  1  registered; high while a deferred fetch is being served.

Behaviour:
- Reset (rst=0, asynchronous):
  - inst_sram_rdata=0, data_sram_rdata=0, stallreq=0, state=IDLE.
  - Latched fetch address cleared. RAM contents are not reset.
- Address mapping: physical address = addr & 32'h1FFF_FFFF. Bits [1:0] are ignored (word access only).
- States: IDLE, INST_PEND.
- IDLE, only one port enabled:
  - That port is served at this edge.
  - Read: the matching rdata register loads RAM[idx] at the next edge (1-cycle latency).
  - Data write: for each set wen bit, RAM byte i takes wdata byte i. data_sram_rdata holds its value.
- IDLE, both ports enabled (conflict, cycle N):
  - Data access is served in N; inst_sram_addr is latched.
  - Next state INST_PEND; stallreq=1 during N+1.
- INST_PEND (cycle N+1):
  - The RAM reads the latched fetch address; inst_sram_rdata is valid in N+2.
  - data_sram_rdata from N's read is valid in N+1 and holds afterwards.
  - Any request presented in N+1 on either port is ignored. The core must hold it, and it is re-evaluated in N+2.
  - Next state IDLE; stallreq=0 in N+2.
- Same-word conflict: a data write in N followed by a deferred fetch of that word returns the newly written data (write-before-read ordering).
- No request: both rdata registers hold their last value; state unchanged.
- inst_sram_wen nonzero: ignored, never writes.
- Reset asserted in INST_PEND: the pending fetch is discarded; outputs go to reset values immediately.
- Back-to-back conflicts: a new conflict in N+2 repeats the sequence. Fetch throughput under continuous conflict is therefore one per 2 cycles.

Optional Feature:
- Macro: SRAM_RESP_ADDR_CHK_EN.
- Defined: a request whose physical address lies outside [BASE, BASE + 4*2^DEPTH_LOG2) is out of window.
  - Out-of-window read returns 32'hDEAD_BEEF.
  - Out-of-window write is suppressed.
  - Sticky output addr_err (1 bit, reset 0) is set and clears only on reset.
- Undefined: no range check and no addr_err port. Address bits above DEPTH_LOG2+1 are ignored, so the RAM aliases across the address space.

Test Plan:
- Reset, then data write 0x1234_5678 with wen=4'hF to 0xBFC0_0010, then data read of the same address → data_sram_rdata=0x1234_5678 one cycle after the read; stallreq stays 0.
- Byte write: wen=4'b0010, wdata=0x0000_AB00 to 0xBFC0_0010, then read → 0x1234_AB78.
- Conflict: same cycle, data write 0xCAFE_F00D to 0xBFC0_0020 and fetch of 0xBFC0_0020 → stallreq=1 next cycle, inst_sram_rdata=0xCAFE_F00D two cycles after request, stallreq back to 0.
- Reset pulse during INST_PEND → stallreq=0 and inst_sram_rdata=0 immediately; after release the next fetch behaves normally.
- Continuous conflicts for 6 cycles, core holding requests while stallreq is high → 3 fetches and 3 data accesses complete, in correct order, with correct data.
- With SRAM_RESP_ADDR_CHK_EN: read 0x0000_0000 → 0xDEAD_BEEF and addr_err=1; write 0x1111_1111 to 0x0000_0000, then in-window reads are unchanged.
